// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and error codes for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_e;

  // Illegal encodings win over misalignment when both apply.
  function automatic logic [1:0] check_access(input logic rd, input logic wr,
                                              input logic [2:0] f3, input logic [1:0] lo);
    logic legal;
    if (rd && wr) return ERR_ILLEGAL;
    if (rd) legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                    (f3 == F3_LBU) || (f3 == F3_LHU);
    else    legal = (f3 <= F3_SW);
    if (!legal) return ERR_ILLEGAL;
    if ((f3[1:0] == 2'd1) && lo[0]) return ERR_MISALIGN;
    if ((f3[1:0] == 2'd2) && (lo != 2'd0)) return ERR_MISALIGN;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/lsu_dmem_if.sv
// rtl/lsu_dmem_if.sv - single-outstanding request/grant/response data-memory bus
interface lsu_dmem_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane replication/strobes and load byte extraction/extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;

  always_comb begin
    wdata    = st_data;
    wstrb    = 4'b0000;
    ld_shift = rdata >> {ld_off, 3'b000};
    ld_data  = ld_shift;

    case (st_funct3)
      F3_SB:   begin wdata = {4{st_data[7:0]}};  wstrb = 4'b0001 << st_off; end
      F3_SH:   begin wdata = {2{st_data[15:0]}}; wstrb = 4'b0011 << st_off; end
      default: wstrb = 4'b1111;
    endcase
    if (!is_store) wstrb = 4'b0000;

    case (ld_funct3)
      F3_LB:   ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_LH:   ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_LBU:  ld_data = {24'd0, ld_shift[7:0]};
      F3_LHU:  ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: bus sequencing, error detection, registered writeback
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_store_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  lsu_dmem_if.master        dmem,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic [31:0]       wb_data,
  output logic              lsu_err,
  output logic [1:0]        lsu_err_code,
  output logic [31:0]       lsu_err_addr
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(BUS_TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic        reg_write_q, store_q;

  logic        accept, is_mem, timeout, latch;
  logic [1:0]  chk;
  logic [31:0] al_wdata, al_ld_data;
  logic [3:0]  al_wstrb;

  logic        wb_fire, wb_rw_d, err_d;
  logic [4:0]  wb_rd_d;
  logic [31:0] wb_data_d, eaddr_d;
  logic [1:0]  code_d;

  assign ex_ready = (state_q == IDLE);
  assign accept   = ex_valid && ex_ready;
  assign is_mem   = ex_mem_read || ex_mem_write;
  assign chk      = check_access(ex_mem_read, ex_mem_write, ex_funct3, ex_alu_result[1:0]);
  assign timeout  = (cnt_q == TIMEOUT_LAST);

  lsu_align u_align (
    .is_store  (ex_mem_write),
    .st_funct3 (ex_funct3),
    .st_off    (ex_alu_result[1:0]),
    .st_data   (ex_store_data),
    .ld_funct3 (funct3_q),
    .ld_off    (addr_q[1:0]),
    .rdata     (dmem.dmem_rdata),
    .wdata     (al_wdata),
    .wstrb     (al_wstrb),
    .ld_data   (al_ld_data)
  );

  // Bus outputs are zero outside REQ so a reset or timeout drops them at once.
  assign dmem.dmem_req   = (state_q == REQ);
  assign dmem.dmem_we    = (state_q == REQ) && store_q;
  assign dmem.dmem_addr  = (state_q == REQ) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign dmem.dmem_wdata = (state_q == REQ) ? wdata_q : 32'd0;
  assign dmem.dmem_wstrb = (state_q == REQ) ? wstrb_q : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    wb_fire   = 1'b0;
    wb_rw_d   = 1'b0;
    wb_rd_d   = rd_q;
    wb_data_d = 32'd0;
    err_d     = 1'b0;
    code_d    = ERR_NONE;
    eaddr_d   = 32'd0;

    case (state_q)
      IDLE: if (accept) begin
        wb_rd_d = ex_rd;
        if (!is_mem) begin
          wb_fire   = 1'b1;
          wb_rw_d   = ex_reg_write;
          wb_data_d = ex_alu_result;
        end else if (chk != ERR_NONE) begin
          wb_fire = 1'b1;
          err_d   = 1'b1;
          code_d  = chk;
          eaddr_d = ex_alu_result;
        end else begin
          latch   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // A grant in the last counted cycle still completes the access.
        if (dmem.dmem_gnt) begin
          if (store_q) begin
            wb_fire = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end else if (timeout) begin
          wb_fire = 1'b1;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          eaddr_d = addr_q;
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (dmem.dmem_rvalid) begin
          wb_fire   = 1'b1;
          wb_rw_d   = reg_write_q;
          wb_data_d = al_ld_data;
          state_d   = IDLE;
        end else if (timeout) begin
          wb_fire = 1'b1;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          eaddr_d = addr_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 8'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      funct3_q     <= 3'd0;
      rd_q         <= 5'd0;
      reg_write_q  <= 1'b0;
      store_q      <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_reg_write <= 1'b0;
      wb_data      <= 32'd0;
      lsu_err      <= 1'b0;
      lsu_err_code <= 2'd0;
      lsu_err_addr <= 32'd0;
    end else begin
      if (latch) begin
        addr_q      <= ex_alu_result;
        wdata_q     <= al_wdata;
        wstrb_q     <= al_wstrb;
        funct3_q    <= ex_funct3;
        rd_q        <= ex_rd;
        reg_write_q <= ex_reg_write;
        store_q     <= ex_mem_write;
        cnt_q       <= 8'd0;
      end else if (state_q != IDLE) begin
        cnt_q <= cnt_q + 8'd1;
      end
      wb_valid     <= wb_fire;
      wb_rd        <= wb_rd_d;
      wb_reg_write <= wb_rw_d;
      wb_data      <= wb_data_d;
      lsu_err      <= err_d;
      lsu_err_code <= code_d;
      lsu_err_addr <= eaddr_d;
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage sitting directly downstream of the execute-stage ALU. Consumes the ALU result as the effective address (or passes it through for non-memory ops), drives a single-outstanding request/grant/response data-memory bus, aligns store data into byte lanes, extracts and extends load data, and produces a registered writeback bundle. Stalls execute while a memory transaction is in flight.

Parameters:
BUS_TIMEOUT, 255, cycles in REQ+WAIT before a bus error is declared (8-bit counter, 1..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  execute stage presents an instruction
ex_ready  out  1  stage can accept (high only in IDLE)
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_funct3  in  3  RV32I load/store width code
ex_alu_result  in  32  effective address or ALU result
ex_store_data  in  32  rs2 value
ex_rd  in  5  destination register
ex_reg_write  in  1  writes rd
dmem_req  out  1  bus request
dmem_we  out  1  write enable
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  out  32  lane-replicated store data
dmem_wstrb  out  4  byte enables
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read word
wb_valid  out  1  writeback bundle valid (one-cycle pulse per instruction)
wb_rd  out  5  destination
wb_reg_write  out  1  commit rd
wb_data  out  32  result
lsu_err  out  1  one-cycle error pulse, coincident with wb_valid
lsu_err_code  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout
lsu_err_addr  out  32  faulting effective address

Behaviour:
- Reset (async, rst_n low): state IDLE, timeout counter 0, all outputs 0 except ex_ready=1 after state is IDLE; dmem_req drops immediately, in-flight transaction abandoned, no wb_valid produced for it.
- FSM states IDLE, REQ, WAIT. Accept = ex_valid && ex_ready.
- Non-memory op accepted: wb_valid=1 next cycle, wb_data=ex_alu_result, wb_rd/wb_reg_write copied; stays IDLE; back-to-back at one per cycle.
- Memory op accepted: check first. Illegal funct3 (load: 3,6,7; store: >2) -> code 10. Misaligned (half: addr[0]=1; word: addr[1:0]!=0) -> code 01. On error: no bus request, next cycle wb_valid=1, wb_reg_write=0, lsu_err=1. Illegal takes priority over misaligned. mem_read and mem_write both high is illegal (code 10).
- Valid memory op: latch address, funct3, rd, store lanes; go REQ. dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb held stable until dmem_gnt sampled high.
- Store lanes: SB wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0]; SH wdata={2{d[15:0]}}, wstrb=4'b0011<<addr[1:0]; SW wdata=d, wstrb=4'b1111. dmem_we=0 and wstrb=0 for loads.
- REQ + gnt: store -> IDLE, wb_valid next cycle with wb_reg_write=0, wb_data=0. Load -> WAIT, dmem_req low.
- WAIT + rvalid: shift rdata right by 8*addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; wb_valid next cycle with wb_reg_write=latched flag; -> IDLE. rvalid is ignored outside WAIT.
- Timeout: counter clears on entering REQ, increments each cycle in REQ/WAIT; reaching BUS_TIMEOUT -> IDLE, dmem_req low, wb_valid with wb_reg_write=0, error code 11. Late gnt/rvalid after timeout ignored.
- wb_valid is never asserted on two consecutive cycles for one instruction; rd=0 loads still perform the bus access.

Decomposition:
- Package lsu_pkg: funct3 constants (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2), state enum {IDLE, REQ, WAIT}, error-code constants.
- Sub-module lsu_align (combinational): store lane replication/strobe generation and load extraction/extension; FSM, counter and registers stay in load_store_unit.

Test Plan:
- SB addr 0x0000_1003, data 0x0000_00AB, gnt immediate -> dmem_addr 0x1000, wstrb 4'b1000, wdata 0xABABABAB, wb_valid next cycle with wb_reg_write=0.
- LB addr 0x2001, rdata 0x123480FF -> wb_data 0xFFFFFF80; repeat as LBU -> 0x00000080; LH addr 0x2002 -> 0x00001234.
- LW addr 0x2002 -> no dmem_req, lsu_err=1, code 01, err_addr 0x2002, wb_reg_write=0; funct3=3 load -> code 10.
- gnt delayed 3 cycles on SW 0x3000 -> req/addr/wdata stable 4 cycles, ex_ready low throughout, single wb_valid.
- BUS_TIMEOUT=4, no gnt -> error code 11 after 4 cycles, req drops, later gnt ignored.
- Three back-to-back ALU results 1,2,3 -> wb_valid on three consecutive cycles in order; rst_n low during WAIT -> req low immediately, no wb_valid, ex_ready=1 after release.
